// File: rtl/rv_byte_alu_if.sv
// Request/response handshake bundle for the byte-serial ALU sequencer.
// The execute stage is the master; the sequencer is the slave.
interface rv_byte_alu_if #(
    parameter int W = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero
    );
endinterface

// File: rtl/rv_byte_alu_seq.sv
// Byte-serial ALU: one 8-bit slice stepped LSB-first across the operands.
// Define RV_BYTE_ALU_SLT_EN to implement SLT/SLTU; otherwise they return 0.
module rv_byte_alu_seq #(
    parameter int NBYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    rv_byte_alu_if.slave    bus,
    output logic            busy
);
    localparam int W = 8 * NBYTES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;

    state_t         state_q, state_d;
    logic [2:0]     k_q;
    logic           carry_q;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   res_q;
    logic           zero_q;

    logic           last;
    logic           is_sub;
    logic           cin;
    logic [7:0]     byte_a, byte_b;
    logic [8:0]     sum9;
    logic [7:0]     r_byte;
    logic [W+7:0]   res_cat;
    logic [W-1:0]   res_shift;
    logic [W-1:0]   res_fin;

    assign last   = (k_q == 3'(NBYTES - 1));
    assign byte_a = a_q[7:0];

    always_comb begin
        is_sub = 1'b0;
        unique case (op_q)
            OP_SUB:  is_sub = 1'b1;
`ifdef RV_BYTE_ALU_SLT_EN
            OP_SLT:  is_sub = 1'b1;
            OP_SLTU: is_sub = 1'b1;
`endif
            default: is_sub = 1'b0;
        endcase
    end

    // carry register is cleared on accept; the subtract carry-in is injected at byte 0
    assign cin    = (k_q == 3'd0) ? is_sub : carry_q;
    assign byte_b = is_sub ? ~b_q[7:0] : b_q[7:0];
    assign sum9   = {1'b0, byte_a} + {1'b0, byte_b} + {8'd0, cin};

    always_comb begin
        r_byte = 8'd0;
        unique case (op_q)
            OP_ADD, OP_SUB: r_byte = sum9[7:0];
            OP_AND:         r_byte = byte_a & b_q[7:0];
            OP_OR:          r_byte = byte_a | b_q[7:0];
            OP_XOR:         r_byte = byte_a ^ b_q[7:0];
            default:        r_byte = 8'd0;
        endcase
    end

    assign res_cat   = {r_byte, res_q};
    assign res_shift = res_cat[W+7:8];

    always_comb begin
        res_fin = res_shift;
        unique case (op_q)
`ifdef RV_BYTE_ALU_SLT_EN
            OP_SLT: begin
                res_fin    = '0;
                res_fin[0] = (a_q[7] ^ b_q[7]) ? a_q[7] : sum9[7];
            end
            OP_SLTU: begin
                res_fin    = '0;
                res_fin[0] = ~sum9[8];
            end
`else
            OP_SLT:  res_fin = '0;
            OP_SLTU: res_fin = '0;
`endif
            3'b111:  res_fin = '0;
            default: res_fin = res_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid && bus.req_ready) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            carry_q <= 1'b0;
            op_q    <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        op_q    <= bus.req_op;
                        a_q     <= bus.req_a;
                        b_q     <= bus.req_b;
                        k_q     <= 3'd0;
                        carry_q <= 1'b0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 8;
                    b_q     <= b_q >> 8;
                    carry_q <= sum9[8];
                    k_q     <= k_q + 3'd1;
                    if (last) begin
                        res_q  <= res_fin;
                        zero_q <= (res_fin == '0);
                    end else begin
                        res_q  <= res_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_data  = res_q;
    assign bus.rsp_zero  = zero_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_rv_byte_alu_seq.sv
// Directed bench for rv_byte_alu_seq (NBYTES=4).
// SLT/SLTU expectations follow RV_BYTE_ALU_SLT_EN.
module tb_rv_byte_alu_seq;
    logic clk;
    logic rst;
    logic busy;
    int   total;
    int   bad;

    rv_byte_alu_if #(.W(32)) bus ();

    rv_byte_alu_seq #(.NBYTES(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rdy,
                         output logic [31:0] d, output logic z,
                         output int lat);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = rdy;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = 32'hDEAD_BEEF;
        bus.req_b     = 32'hDEAD_BEEF;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d = bus.rsp_data;
        z = bus.rsp_zero;
    endtask

    task automatic op_chk(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        logic [31:0] d;
        logic        z;
        int          lat;
        do_op(op, a, b, 1'b1, d, z, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_data"}, d, exp);
        chk({tag, "_zero"}, {31'd0, z}, {31'd0, exp == 32'd0});
        chk({tag, "_rdy_busy"}, {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_vld_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    logic [31:0] slt_a_exp, sltu_a_exp, slt_b_exp, sltu_b_exp;
    logic [31:0] d;
    logic        z;
    int          lat;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.rsp_ready = 1'b0;
`ifdef RV_BYTE_ALU_SLT_EN
        slt_a_exp  = 32'd1;
        sltu_a_exp = 32'd0;
        slt_b_exp  = 32'd0;
        sltu_b_exp = 32'd1;
`else
        slt_a_exp  = 32'd0;
        sltu_a_exp = 32'd0;
        slt_b_exp  = 32'd0;
        sltu_b_exp = 32'd0;
`endif
        #12;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", bus.rsp_data, 32'd0);
        chk("rst_zero", {31'd0, bus.rsp_zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

        op_chk("add_carry", 3'b000, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100);
        op_chk("sub_neg", 3'b001, 32'd5, 32'd7, 32'hFFFF_FFFE);
        op_chk("sub_eq", 3'b001, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000);
        op_chk("and", 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        op_chk("or", 3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        op_chk("xor", 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        op_chk("slt_a", 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, slt_a_exp);
        op_chk("sltu_a", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, sltu_a_exp);
        op_chk("slt_b", 3'b101, 32'h0000_0001, 32'h8000_0000, slt_b_exp);
        op_chk("sltu_b", 3'b110, 32'h0000_0001, 32'h8000_0000, sltu_b_exp);
        op_chk("rsvd", 3'b111, 32'h1234_5678, 32'h0000_0001, 32'd0);
        op_chk("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);

        // backpressure with a competing request in flight
        do_op(3'b000, 32'h0000_1000, 32'h0000_0234, 1'b0, d, z, lat);
        chk("bp_lat", 32'(lat), 32'd4);
        chk("bp_data0", d, 32'h0000_1234);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.req_valid = (i == 3 || i == 4);
            bus.req_op    = 3'b010;
            bus.req_a     = 32'hAAAA_AAAA;
            bus.req_b     = 32'h5555_5555;
            #1;
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_data", bus.rsp_data, 32'h0000_1234);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_consumed", {31'd0, bus.rsp_valid}, 32'd0);
        chk("bp_idle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("bp_once", {31'd0, bus.rsp_valid}, 32'd0);
        chk("bp_no_accept", {31'd0, busy}, 32'd0);

        // reset after two committed bytes of a carrying add
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b000;
        bus.req_a     = 32'h00FF_FFFF;
        bus.req_b     = 32'h0000_0001;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mid_rst_data", bus.rsp_data, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("mid_rst_zero", {31'd0, bus.rsp_zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_post_ready", {31'd0, bus.req_ready}, 32'd1);
        op_chk("add_after_rst", 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        op_chk("add_zero", 3'b000, 32'd0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rv_byte_alu_seq.md
# rv_byte_alu_seq

Byte-serial ALU sequencer for the hands-on RISC-V core. It accepts one 32-bit (parameterisable) ALU request over a valid/ready handshake. It steps a single 8-bit adder/logic slice across the operand bytes, LSB first, carrying between bytes, and returns the result over a second valid/ready handshake. It sits between the core's execute stage and the shared 8-bit datapath, trading latency for area on the tile.

## Interface

Parameters:
- NBYTES, default 4: operand width in bytes; data width W = 8*NBYTES; legal range 1..8.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  operation code:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLT, 110 SLTU.
  - 111 reserved.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  W  result.
- rsp_zero  out  1  rsp_data == 0.
- busy  out  1  state != IDLE.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready = 1 (forced 0 while rst is high).
  - On req_valid & req_ready at an edge: latch op, A and B; clear byte index k and carry; go to RUN.
  - Operand inputs are don't-care after acceptance.
- RUN:
  - Each cycle processes byte k of the latched A and B.
  - ADD: {c, r[k]} = a[k] + b[k] + c.
  - SUB, SLT, SLTU: b[k] is inverted; initial carry-in is 1.
  - AND, OR, XOR: bytewise; carry is unused.
  - r[k] is written into the result register at the edge; carry is registered; k increments.
  - After byte NBYTES-1, go to DONE.
- Result fix-up on the transition into DONE:
  - SLT: result = (a_msb ^ b_msb) ? a_msb : diff_msb, zero-extended to W.
  - SLTU: result = ~carry_out, zero-extended to W.
  - op 111: result = 0.
- DONE:
  - rsp_valid = 1; rsp_data and rsp_zero are held stable until rsp_valid & rsp_ready at an edge, then go to IDLE.
  - req_ready = 0; req_valid is ignored.
- rsp_zero is registered together with the final result, not derived combinationally from a changing register.
- Arithmetic wraps modulo 2^W; no overflow flag.

## Timing

- Acceptance edge is E0. Byte k is committed at edge E0+k+1.
- rsp_valid rises after edge E0+NBYTES, giving NBYTES cycles of latency for every op.
- If rsp_ready is already high, the response handshake completes at edge E0+NBYTES+1.
- req_ready is high again in the following cycle, so there is no back-to-back accept.
- Minimum issue interval is NBYTES+2 cycles.
- req_ready and rsp_valid are functions of state only, with no combinational path from req_valid or rsp_ready.
- Reset, asynchronous at any time including mid-RUN or in DONE:
  - state = IDLE; k = 0; carry = 0.
  - rsp_valid = 0; rsp_data = 0; rsp_zero = 1 (reflects rsp_data = 0); busy = 0; req_ready = 0 while rst is high.
  - Any in-flight request is discarded with no response.
- After rst deasserts, req_ready = 1 in the first cycle.

## Configuration

- RV_BYTE_ALU_SLT_EN:
  - Defined: SLT and SLTU are implemented as described.
  - Undefined: ops 101 and 110 behave as reserved, returning result 0 with the same latency. The MSB/carry fix-up logic is removed.

## Test plan

- ADD, A=0x0000_00FF, B=0x0000_0001, rsp_ready=1:
  - rsp_data=0x0000_0100, rsp_zero=0.
  - rsp_valid rises exactly 4 edges after acceptance.
  - req_ready returns 1 six cycles after acceptance.
- SUB:
  - A=5, B=7 gives 0xFFFF_FFFE, rsp_zero=0.
  - A=B=0x1234_5678 gives 0x0000_0000, rsp_zero=1.
- Logic ops, A=0xF0F0_F0F0, B=0xFF00_FF00:
  - AND gives 0xF000_F000.
  - OR gives 0xFFF0_FFF0.
  - XOR gives 0x0FF0_0FF0.
- SLT/SLTU, A=0xFFFF_FFFF, B=0x0000_0001:
  - With RV_BYTE_ALU_SLT_EN: SLT gives 1, SLTU gives 0.
  - With RV_BYTE_ALU_SLT_EN and A=1, B=0x8000_0000: SLT gives 0, SLTU gives 1.
  - Without the macro: all four cases give 0.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid, and pulse req_valid with a new request meanwhile.
  - rsp_data and rsp_valid stay stable; req_ready stays 0; the new request is not accepted.
  - After rsp_ready=1, the response is consumed once.
- Reset mid-RUN: assert rst after 2 bytes of an ADD are committed.
  - Immediately: rsp_valid=0, rsp_data=0, busy=0.
  - After release, ADD 0x7FFF_FFFF+1 gives 0x8000_0000 with normal latency and no stale carry.
